// File: rtl/beacon_period_meter.sv
// Beacon period meter: measures the rising-edge period of an asynchronous beacon
// signal in timebase ticks, flags a stable frequency and times out when the beacon
// disappears. Optional glitch filter: define PERIOD_METER_DEBOUNCE_EN.
module beacon_period_meter #(
  parameter int WIDTH    = 16,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TMO     = 2'd2
  } state_t;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_lvl;
  logic w_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
    end
  end

`ifdef PERIOD_METER_DEBOUNCE_EN
  logic       r_filt;
  logic [1:0] r_db_cnt;

  // The filtered level follows s2 only after s2 has disagreed with it for 3 clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt   <= 1'b0;
      r_db_cnt <= 2'd0;
    end else if (r_s2 == r_filt) begin
      r_db_cnt <= 2'd0;
    end else if (r_db_cnt == 2'd2) begin
      r_filt   <= r_s2;
      r_db_cnt <= 2'd0;
    end else begin
      r_db_cnt <= r_db_cnt + 2'd1;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3 <= 1'b0;
    end else begin
      r_s3 <= w_lvl;
    end
  end

  assign w_edge = w_lvl & ~r_s3;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_last;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;
  logic             r_prev_valid;
  logic [MCW-1:0]   r_match_cnt;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_period_next;
  logic [WIDTH-1:0] w_last_next;
  logic             w_valid_next;
  logic             w_locked_next;
  logic             w_timeout_next;
  logic             w_prev_valid_next;
  logic [MCW-1:0]   w_match_cnt_next;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_new_period;
  logic [WIDTH:0]   w_diff;
  logic             w_match;
  logic [MCW-1:0]   w_match_inc;

  // A tick that coincides with the closing edge still belongs to the ending period.
  assign w_sum        = {1'b0, r_count} + {{WIDTH{1'b0}}, tick};
  assign w_new_period = w_sum[WIDTH] ? CNT_MAX : w_sum[WIDTH-1:0];
  assign w_diff       = (w_new_period >= r_last) ? ({1'b0, w_new_period} - {1'b0, r_last})
                                                 : ({1'b0, r_last} - {1'b0, w_new_period});
  assign w_match      = r_prev_valid && (w_diff <= (WIDTH+1)'(TOL));
  assign w_match_inc  = (r_match_cnt == MCW'(LOCK_CNT)) ? r_match_cnt : r_match_cnt + MCW'(1);

  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_period_next     = r_period;
    w_last_next       = r_last;
    w_valid_next      = 1'b0;
    w_locked_next     = r_locked;
    w_timeout_next    = r_timeout;
    w_prev_valid_next = r_prev_valid;
    w_match_cnt_next  = r_match_cnt;
    if (en) begin
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            w_state_next      = MEASURE;
            w_count_next      = '0;
            w_prev_valid_next = 1'b0;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            w_period_next     = w_new_period;
            w_valid_next      = 1'b1;
            w_count_next      = '0;
            w_last_next       = w_new_period;
            w_prev_valid_next = 1'b1;
            if (w_match) begin
              w_match_cnt_next = w_match_inc;
              w_locked_next    = (w_match_inc == MCW'(LOCK_CNT));
            end else begin
              w_match_cnt_next = '0;
              w_locked_next    = 1'b0;
            end
          end else if (tick) begin
            if (r_count == CNT_MAX) begin
              w_state_next      = TMO;
              w_timeout_next    = 1'b1;
              w_locked_next     = 1'b0;
              w_match_cnt_next  = '0;
              w_prev_valid_next = 1'b0;
            end else begin
              w_count_next = r_count + WIDTH'(1);
            end
          end
        end
        TMO: begin
          if (w_edge) begin
            w_state_next   = MEASURE;
            w_timeout_next = 1'b0;
            w_count_next   = '0;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_period     <= '0;
      r_last       <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
      r_prev_valid <= 1'b0;
      r_match_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_period     <= w_period_next;
      r_last       <= w_last_next;
      r_valid      <= w_valid_next;
      r_locked     <= w_locked_next;
      r_timeout    <= w_timeout_next;
      r_prev_valid <= w_prev_valid_next;
      r_match_cnt  <= w_match_cnt_next;
    end
  end

  assign period  = r_period;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_beacon_period_meter.sv
// Testbench for beacon_period_meter (WIDTH=8): directed scenarios plus randomized
// beacon traffic, checked every cycle against an edge/tick-level reference model.
module tb_beacon_period_meter;

  localparam int W    = 8;
  localparam int TOL  = 2;
  localparam int LC   = 4;
  localparam int PMAX = (1 << W) - 1;
`ifdef PERIOD_METER_DEBOUNCE_EN
  localparam int D = 5;
`else
  localparam int D = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         tick = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic         valid;
  logic         locked;
  logic         timeout;

  always #5 clk = ~clk;

  beacon_period_meter #(.WIDTH(W), .TOL(TOL), .LOCK_CNT(LC)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick   (tick),
    .sig_in (sig_in),
    .period (period),
    .valid  (valid),
    .locked (locked),
    .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for first edge, 1 = measuring, 2 = timed out.
  bit hist[0:7];
  int m_phase, m_ticks, m_last, m_have_last, m_streak;
  int m_period, m_valid, m_locked, m_timeout;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    m_phase = 0; m_ticks = 0; m_last = 0; m_have_last = 0; m_streak = 0;
    m_period = 0; m_valid = 0; m_locked = 0; m_timeout = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit e, input bit gl);
    bit ed;
    int p, d;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
`ifdef PERIOD_METER_DEBOUNCE_EN
    hist[0] = gl ? 1'b0 : s;
`else
    hist[0] = s;
`endif
    ed = hist[D] && !hist[D+1];
    m_valid = 0;
    if (!e) return;
    if (ed) begin
      if (m_phase == 1) begin
        p = m_ticks + (t ? 1 : 0);
        if (p > PMAX) p = PMAX;
        d = (p > m_last) ? p - m_last : m_last - p;
        if (m_have_last != 0 && d <= TOL) m_streak = (m_streak + 1 > LC) ? LC : m_streak + 1;
        else m_streak = 0;
        m_locked = (m_streak == LC) ? 1 : 0;
        m_period = p; m_valid = 1; m_last = p; m_have_last = 1; m_ticks = 0;
      end else begin
        m_phase = 1; m_ticks = 0; m_timeout = 0; m_have_last = 0;
      end
    end else if (m_phase == 1 && t) begin
      m_ticks++;
      if (m_ticks > PMAX) begin
        m_phase = 2; m_timeout = 1; m_locked = 0; m_streak = 0; m_have_last = 0;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit t, input bit e, input bit gl);
    sig_in = s; tick = t; en = e;
    @(posedge clk);
    model_step(s, t, e, gl);
    #1;
    check_val("period", int'(period), m_period);
    check_val("valid", int'(valid), m_valid);
    check_val("locked", int'(locked), m_locked);
    check_val("timeout", int'(timeout), m_timeout);
    if (valid) $display("txn t=%0t period=%0d locked=%0d", $time, period, locked);
  endtask

  // One beacon cycle: high for hl clk, low for the rest; tmode 1 = tick every clk, 0 = none.
  task automatic run_sig(input int len, input int hl, input int tmode);
    for (int i = 0; i < len; i++) cyc(i < hl, tmode != 0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_period", int'(period), 0);
    check_val("rst_valid", int'(valid), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_timeout", int'(timeout), 0);
    #2 rst = 1'b1;

    // Steady 100-tick beacon locks on the 6th edge.
    for (int k = 0; k < 7; k++) run_sig(100, 50, 1);
    check_val("t1_period", int'(period), 100);
    check_val("t1_locked", int'(locked), 1);

    // Jitter within tolerance keeps lock, a 110 period breaks it, then relock.
    run_sig(100, 50, 1);
    run_sig(101, 50, 1);
    run_sig(99, 50, 1);
    run_sig(101, 50, 1);
    for (int k = 0; k < 6; k++) run_sig(110, 50, 1);
    check_val("t2_relocked", int'(locked), 1);

    // 20 clk of en=0 mid-period removes 20 ticks.
    for (int i = 0; i < 100; i++) cyc(i < 50, 1'b1, !(i >= 40 && i < 60), 1'b0);
    run_sig(100, 50, 1);
    check_val("en_gap_period", int'(period), 80);
    // A rising edge while disabled is lost.
    for (int i = 0; i < 60; i++) cyc(i < 30, 1'b1, i >= 10, 1'b0);
    run_sig(100, 50, 1);

    // Beacon disappears: timeout, re-arm, then valid again.
    run_sig(300, 50, 1);
    check_val("to_flag", int'(timeout), 1);
    check_val("to_locked", int'(locked), 0);
    run_sig(100, 50, 1);
    check_val("to_cleared", int'(timeout), 0);
    run_sig(100, 50, 1);

    // 256 ticks in one period saturates to 255 without timing out.
    run_sig(256, 50, 1);
    run_sig(50, 20, 1);
    check_val("sat_period", int'(period), PMAX);
    check_val("sat_timeout", int'(timeout), 0);

    // Edges with no tick between them measure zero.
    for (int k = 0; k < 3; k++) run_sig(10, 5, 0);
    check_val("zero_period", int'(period), 0);

    // Short glitch between two edges 100 clk apart.
    run_sig(100, 10, 1);
    for (int i = 0; i < 100; i++) cyc(i < 10 || i == 50 || i == 51, 1'b1, 1'b1, i == 50 || i == 51);
    run_sig(100, 10, 1);
`ifdef PERIOD_METER_DEBOUNCE_EN
    check_val("glitch_period", int'(period), 100);
`else
    check_val("glitch_period", int'(period), 50);
`endif

    // Asynchronous reset while locked.
    for (int k = 0; k < 7; k++) run_sig(60, 30, 1);
    check_val("pre_rst_locked", int'(locked), 1);
    for (int i = 0; i < 25; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_val("arst_period", int'(period), 0);
    check_val("arst_valid", int'(valid), 0);
    check_val("arst_locked", int'(locked), 0);
    check_val("arst_timeout", int'(timeout), 0);
    model_reset();
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) run_sig(60, 30, 1);

    // Random traffic: sparse ticks and occasional disable.
    for (int k = 0; k < 30; k++) begin
      int hl, ll;
      hl = $urandom_range(5, 30);
      ll = $urandom_range(5, 30);
      for (int i = 0; i < hl + ll; i++)
        cyc(i < hl, 1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0, 1'b0);
    end
    // Random jitter around 40 ticks, sometimes beyond tolerance.
    for (int k = 0; k < 25; k++) run_sig(40 + $urandom_range(0, 3), 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
